sweep_scheduler: RTL and testbench

- Frequency-sweep sequencer for the ADC -> CORDIC downconvert -> decimator -> upsampler -> CORDIC upconvert -> DAC chain.
- Drives the chain's phase_inc and steps it from a start to a stop value.
- After each step it blanks a settling interval, then integrates |I|+|Q| of the decimated outputs over a dwell window.
- Each point's result goes out on a valid/ready stream for the SoC (CSR FIFO / DMA).

---
 rtl/sweep_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: frequency-sweep sequencer for the downconvert/upconvert chain.
// Steps phase_inc from a start to a stop increment. After each step it discards a
// settling interval of decimated samples, then integrates |I|+|Q| over a dwell
// window and reports each point on a result stream.
// Optional feature macro: SWEEP_SCHEDULER_PEAK_EN adds peak_inc/peak_mag, which
// track the strongest point of the current sweep.
//
// Result stream: a result transfers on a rising sys_clk edge where
// res_valid && res_ready. Once res_valid is high it stays high, and
// res_inc/res_mag/res_sat hold their values, until that transfer. Only abort or
// reset can withdraw it.
module sweep_scheduler #(
  parameter int PW    = 19,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACC_W = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [PW-1:0]    cfg_start_inc,
  input  logic [PW-1:0]    cfg_stop_inc,
  input  logic [PW-1:0]    cfg_step_inc,
  input  logic [CW-1:0]    cfg_settle,
  input  logic [CW-1:0]    cfg_dwell,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_ce,
  input  logic [DW-1:0]    sample_i,
  input  logic [DW-1:0]    sample_q,
  output logic [PW-1:0]    phase_inc,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PW-1:0]    res_inc,
  output logic [ACC_W-1:0] res_mag,
  output logic             res_sat,
`ifdef SWEEP_SCHEDULER_PEAK_EN
  output logic [PW-1:0]    peak_inc,
  output logic [ACC_W-1:0] peak_mag,
`endif
  output logic [2:0]       dbg_state
);

  // Sum width covers both the accumulator and one sample magnitude plus a carry,
  // so overflow past the accumulator range is always visible.
  localparam int MAG_W = DW + 2;
  localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DWELL  = 3'd2,
    S_REPORT = 3'd3,
    S_STEP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_d;

  // Configuration captured on the accepted start; cfg_* is ignored mid-sweep.
  logic [PW-1:0]    stop_r;
  logic [PW-1:0]    step_r;
  logic [CW-1:0]    settle_r;
  logic [CW-1:0]    dwell_r;

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic             sat;

  logic             start_ok;
  logic             abort_hit;
  logic             handshake;
  logic             settle_hit;
  logic             dwell_hit;
  logic             last_pt;
  logic [CW:0]      cnt_inc;
  logic [CW-1:0]    dwell_eff;

  logic [DW:0]      ext_i, ext_q;
  logic [DW:0]      abs_i, abs_q;
  logic [MAG_W-1:0] mag;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] acc_max_ext;
  logic             sat_now;
  logic [ACC_W-1:0] acc_nxt;

  assign start_ok   = (state == S_IDLE) && start;
  assign abort_hit  = abort && (state != S_IDLE);
  assign handshake  = res_valid && res_ready;
  assign settle_hit = (cnt == settle_r);
  assign cnt_inc    = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign dwell_eff  = (dwell_r == '0) ? {{(CW-1){1'b0}}, 1'b1} : dwell_r;
  assign dwell_hit  = (cnt_inc == {1'b0, dwell_eff});

  // Unsigned, wrap-free test: the next step would pass stop (or there is no step).
  assign last_pt = (step_r == '0) || (phase_inc >= stop_r) ||
                   ((stop_r - phase_inc) < step_r);

  // Magnitudes in DW+1 bits so the most negative input maps to +2^(DW-1).
  assign ext_i = {sample_i[DW-1], sample_i};
  assign ext_q = {sample_q[DW-1], sample_q};
  assign abs_i = sample_i[DW-1] ? -ext_i : ext_i;
  assign abs_q = sample_q[DW-1] ? -ext_q : ext_q;
  assign mag   = MAG_W'(abs_i) + MAG_W'(abs_q);

  // Saturating accumulate: clamp to all-ones when the true sum exceeds the range.
  assign sum         = SUM_W'(acc) + SUM_W'(mag);
  assign acc_max_ext = SUM_W'({ACC_W{1'b1}});
  assign sat_now     = (sum > acc_max_ext);
  assign acc_nxt     = sat_now ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  // The reported point is the live increment and accumulator, both frozen in REPORT.
  assign res_inc   = phase_inc;
  assign res_mag   = acc;
  assign res_sat   = sat;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start_ok) state_d = S_SETTLE;
      S_SETTLE: if (settle_hit) state_d = S_DWELL;
      S_DWELL:  if (sample_ce && dwell_hit) state_d = S_REPORT;
      S_REPORT: if (handshake) state_d = last_pt ? S_DONE : S_STEP;
      S_STEP:   state_d = S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // Datapath: config capture, counters, accumulator and the result/status flags.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_r    <= '0;
      step_r    <= '0;
      settle_r  <= '0;
      dwell_r   <= '0;
      phase_inc <= '0;
      cnt       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
    end else if (abort_hit) begin
      // phase_inc is deliberately kept so the chain stays where the sweep stopped.
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            stop_r    <= cfg_stop_inc;
            step_r    <= cfg_step_inc;
            settle_r  <= cfg_settle;
            dwell_r   <= cfg_dwell;
            phase_inc <= cfg_start_inc;
            acc       <= '0;
            sat       <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
          end
        end
        S_SETTLE: begin
          // A strobe on the exit cycle is dropped; DWELL starts counting afresh.
          if (settle_hit)     cnt <= '0;
          else if (sample_ce) cnt <= cnt_inc[CW-1:0];
        end
        S_DWELL: begin
          if (sample_ce) begin
            acc <= acc_nxt;
            sat <= sat | sat_now;
            cnt <= cnt_inc[CW-1:0];
            if (dwell_hit) res_valid <= 1'b1;
          end
        end
        S_REPORT: begin
          if (handshake) begin
            res_valid <= 1'b0;
            if (last_pt) done <= 1'b1;
          end
        end
        S_STEP: begin
          phase_inc <= phase_inc + step_r;
          acc       <= '0;
          sat       <= 1'b0;
          cnt       <= '0;
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SWEEP_SCHEDULER_PEAK_EN
  // Peak tracker: strictly larger magnitude wins, so ties keep the earlier point.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_inc <= '0;
      peak_mag <= '0;
    end else if (start_ok) begin
      peak_inc <= '0;
      peak_mag <= '0;
    end else if ((state == S_REPORT) && handshake && !abort && (acc > peak_mag)) begin
      peak_inc <= phase_inc;
      peak_mag <= acc;
    end
  end
`endif

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler: directed bench for sweep_scheduler.
// Two instances share all stimulus: the default 32-bit accumulator and a 16-bit
// accumulator that can be driven into saturation. Expected points come from a
// point-list model (start, start+step, ... <= stop; dwell_eff * (|I|+|Q|) each).
module tb_sweep_scheduler;
  localparam int PW    = 19;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACC_W = 32;

  logic             sys_clk;
  logic             rst_n;
  logic [PW-1:0]    cfg_start_inc, cfg_stop_inc, cfg_step_inc;
  logic [CW-1:0]    cfg_settle, cfg_dwell;
  logic             start, abort, sample_ce, res_ready;
  logic [DW-1:0]    sample_i, sample_q;

  logic [PW-1:0]    phase_inc, res_inc;
  logic             busy, done, res_valid, res_sat;
  logic [ACC_W-1:0] res_mag;
  logic [2:0]       dbg_state;

  logic [PW-1:0]    phase_inc16, res_inc16;
  logic             busy16, done16, res_valid16, res_sat16;
  logic [15:0]      res_mag16;
  logic [2:0]       dbg_state16;
`ifdef SWEEP_SCHEDULER_PEAK_EN
  logic [PW-1:0]    peak_inc, peak_inc16;
  logic [ACC_W-1:0] peak_mag;
  logic [15:0]      peak_mag16;
`endif

  sweep_scheduler #(.PW(PW), .DW(DW), .CW(CW), .ACC_W(ACC_W)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc), .cfg_step_inc(cfg_step_inc),
    .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell),
    .start(start), .abort(abort), .sample_ce(sample_ce),
    .sample_i(sample_i), .sample_q(sample_q),
    .phase_inc(phase_inc), .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_inc(res_inc), .res_mag(res_mag), .res_sat(res_sat),
`ifdef SWEEP_SCHEDULER_PEAK_EN
    .peak_inc(peak_inc), .peak_mag(peak_mag),
`endif
    .dbg_state(dbg_state)
  );

  sweep_scheduler #(.PW(PW), .DW(DW), .CW(CW), .ACC_W(16)) u_dut16 (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc), .cfg_step_inc(cfg_step_inc),
    .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell),
    .start(start), .abort(abort), .sample_ce(sample_ce),
    .sample_i(sample_i), .sample_q(sample_q),
    .phase_inc(phase_inc16), .busy(busy16), .done(done16),
    .res_valid(res_valid16), .res_ready(res_ready),
    .res_inc(res_inc16), .res_mag(res_mag16), .res_sat(res_sat16),
`ifdef SWEEP_SCHEDULER_PEAK_EN
    .peak_inc(peak_inc16), .peak_mag(peak_mag16),
`endif
    .dbg_state(dbg_state16)
  );

  // ---------------- clock ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_res = 0;      // results accepted (written only by the compare process)
  int n_done = 0;     // done pulses seen (written only by the compare process)
  int pt_base = 0;    // n_res at the start of the current sweep
  int ce_period = 8;
  int pt_i[0:7];
  int pt_q[0:7];

  logic [PW-1:0] exp_inc_q[$];
  logic [39:0]   exp_tot_q[$];
  longint        mpk_inc, mpk_mag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] maxv(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] clip(input logic [39:0] t, input int w);
    return ({24'd0, t} > maxv(w)) ? maxv(w) : {24'd0, t};
  endfunction

  function automatic longint iabs(input int v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  task automatic set_pts(input int i, input int q);
    for (int k = 0; k < 8; k++) begin
      pt_i[k] = i;
      pt_q[k] = q;
    end
  endtask

  // Model: enumerate the point list and each point's integrated magnitude.
  task automatic push_model(input longint s, input longint e, input longint st, input int dw);
    longint p;
    longint tot;
    int k;
    int dwe;
    p = s;
    k = 0;
    dwe = (dw == 0) ? 1 : dw;
    mpk_inc = 0;
    mpk_mag = 0;
    while (1) begin
      tot = dwe * (iabs(pt_i[k]) + iabs(pt_q[k]));
      exp_inc_q.push_back(p[PW-1:0]);
      exp_tot_q.push_back(tot[39:0]);
      if (tot > mpk_mag) begin
        mpk_mag = tot;
        mpk_inc = p;
      end
      k++;
      if (st == 0 || p + st > e || k >= 8) break;
      p = p + st;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int s, input int e, input int st, input int se, input int dw);
    @(posedge sys_clk); #1;
    pt_base = n_res;
    push_model(s, e, st, dw);
    cfg_start_inc = s[PW-1:0];
    cfg_stop_inc  = e[PW-1:0];
    cfg_step_inc  = st[PW-1:0];
    cfg_settle    = se[CW-1:0];
    cfg_dwell     = dw[CW-1:0];
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    // Scramble the config: the sweep must run on the captured copy.
    cfg_start_inc = PW'($urandom_range(524287, 0));
    cfg_stop_inc  = PW'($urandom_range(524287, 0));
    cfg_step_inc  = PW'($urandom_range(524287, 0));
    cfg_settle    = CW'($urandom_range(65535, 0));
    cfg_dwell     = CW'($urandom_range(65535, 0));
    @(negedge sys_clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_valid(input string name, input int limit);
    int k;
    k = 0;
    while (res_valid !== 1'b1 && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    check(name, res_valid, 1);
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (2) @(negedge sys_clk);
    check({name, "_done_count"}, n_done - d0, 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_left_points"}, exp_inc_q.size(), 0);
    check({name, "_point_count"}, n_res - pt_base, 0 + n_res - pt_base == 0 ? 64'hDEAD : n_res - pt_base);
  endtask

  // ---------------- sample source ----------------
  initial begin
    int cyc;
    int idx;
    cyc = 0;
    sample_ce = 1'b0;
    sample_i  = '0;
    sample_q  = '0;
    forever begin
      @(posedge sys_clk); #1;
      cyc++;
      sample_ce = ((cyc % ce_period) == 0);
      idx = n_res - pt_base;
      if (idx < 0) idx = 0;
      if (idx > 7) idx = 7;
      sample_i = pt_i[idx][DW-1:0];
      sample_q = pt_q[idx][DW-1:0];
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1) begin
        if (res_valid === 1'b1) begin
          if (exp_inc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_res: res_valid=1 res_inc=%0d, required no outstanding point", res_inc);
          end else begin
            check("res_inc", res_inc, exp_inc_q[0]);
            check("phase_inc_in_report", phase_inc, exp_inc_q[0]);
            check("res_mag", res_mag, clip(exp_tot_q[0], ACC_W));
            check("res_sat", res_sat, {24'd0, exp_tot_q[0]} > maxv(ACC_W));
            check("res_valid16", res_valid16, 1);
            check("res_mag16", res_mag16, clip(exp_tot_q[0], 16));
            check("res_sat16", res_sat16, {24'd0, exp_tot_q[0]} > maxv(16));
            if (res_ready === 1'b1) begin
              void'(exp_inc_q.pop_front());
              void'(exp_tot_q.pop_front());
              n_res++;
            end
          end
        end
        if (done === 1'b1) begin
          check("done_after_last", exp_inc_q.size(), 0);
          n_done++;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    cfg_start_inc = '0;
    cfg_stop_inc  = '0;
    cfg_step_inc  = '0;
    cfg_settle    = '0;
    cfg_dwell     = '0;
    set_pts(100, -50);

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_phase_inc", phase_inc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_state", dbg_state, 0);

    // Basic sweep: 1000..1300 step 100, dwell 4 of |100|+|-50|.
    do_start(1000, 1300, 100, 2, 4);
    check("model_basic_points", exp_inc_q.size(), 4);
    check("model_basic_mag", exp_tot_q[0], 600);
    wait_done("basic", 2000);
    check("basic_phase_end", phase_inc, 1300);

    // Stop not on the step grid: last point 1200.
    do_start(1000, 1250, 100, 2, 4);
    check("model_unaligned_last", exp_inc_q[exp_inc_q.size()-1], 1200);
    wait_done("unaligned", 2000);
    check("unaligned_phase_end", phase_inc, 1200);

    // Zero step: one point.
    do_start(1000, 1300, 0, 1, 2);
    check("model_step0_points", exp_inc_q.size(), 1);
    wait_done("step0", 1000);
    check("step0_phase_end", phase_inc, 1000);

    // Start above stop: one point at start.
    do_start(2000, 1000, 100, 0, 2);
    wait_done("start_gt_stop", 1000);
    check("start_gt_stop_phase", phase_inc, 2000);

    // Dwell 0 behaves as 1, settle 0, back-to-back strobes.
    ce_period = 1;
    set_pts(-7, 300);
    do_start(10, 30, 10, 0, 0);
    check("model_dwell0_mag", exp_tot_q[0], 307);
    wait_done("dwell0", 500);
    ce_period = 8;

    // Backpressure: first result held for 50 cycles while strobes continue.
    set_pts(100, -50);
    res_ready = 1'b0;
    do_start(1000, 1300, 100, 2, 4);
    wait_valid("bp_valid", 1000);
    repeat (50) @(negedge sys_clk);
    check("bp_valid_held", res_valid, 1);
    check("bp_inc_held", res_inc, 1000);
    check("bp_mag_held", res_mag, 600);
    check("bp_phase_held", phase_inc, 1000);
    @(posedge sys_clk); #1;
    res_ready = 1'b1;
    wait_done("bp", 2000);

    // Saturation on the 16-bit instance, cleared on the next point.
    pt_i[0] = -32768; pt_q[0] = -32768;
    pt_i[1] = 10;     pt_q[1] = 10;
    do_start(0, 100, 100, 1, 2);
    check("model_sat_tot", exp_tot_q[0], 131072);
    check("model_sat_clip16", clip(exp_tot_q[0], 16), 65535);
    wait_valid("sat_valid", 1000);
    check("sat_mag16", res_mag16, 65535);
    check("sat_flag16", res_sat16, 1);
    check("sat_mag32", res_mag, 131072);
    wait_done("sat", 1000);

    // Abort during SETTLE of point 2.
    set_pts(100, -50);
    do_start(1000, 1300, 100, 5, 1);
    k = 0;
    while (n_res - pt_base < 1 && k < 1000) begin
      @(negedge sys_clk);
      k++;
    end
    check("abort_first_point", n_res - pt_base, 1);
    repeat (3) @(posedge sys_clk);
    #1;
    abort = 1'b1;
    @(posedge sys_clk); #1;
    abort = 1'b0;
    @(negedge sys_clk);
    check("abort_busy", busy, 0);
    check("abort_phase", phase_inc, 1100);
    check("abort_state", dbg_state, 0);
    exp_inc_q.delete();
    exp_tot_q.delete();
    d0 = n_done;
    repeat (40) @(negedge sys_clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_still_idle", busy, 0);

`ifdef SWEEP_SCHEDULER_PEAK_EN
    // Peak: magnitudes 300, 900, 900, 200 -> second point wins the tie.
    pt_i[0] = 300; pt_i[1] = 900; pt_i[2] = 900; pt_i[3] = 200;
    pt_q[0] = 0;   pt_q[1] = 0;   pt_q[2] = 0;   pt_q[3] = 0;
    do_start(500, 800, 100, 0, 1);
    check("model_peak_inc", mpk_inc, 600);
    check("model_peak_mag", mpk_mag, 900);
    wait_done("peak", 1000);
    check("peak_inc", peak_inc, mpk_inc);
    check("peak_mag", peak_mag, mpk_mag);
    check("peak_mag16", peak_mag16, mpk_mag);
    set_pts(100, -50);
`endif

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    do_start(1000, 1300, 100, 2, 4);
`ifdef SWEEP_SCHEDULER_PEAK_EN
    check("peak_cleared_on_start", peak_mag, 0);
`endif
    wait_valid("rst_test_valid", 1000);
    @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_phase_inc", phase_inc, 0);
    check("arst_busy", busy, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_mag", res_mag, 0);
    check("arst_res_inc", res_inc, 0);
    check("arst_done", done, 0);
    exp_inc_q.delete();
    exp_tot_q.delete();
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("arst_state_idle", dbg_state, 0);
    check("arst_phase_after", phase_inc, 0);
    check("arst_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
